imem_arbiter: RTL

- Shares the single-port instruction memory between two requesters: the fetch stage (read-only) and the program loader (write-only).
- Sits between those requesters and the instruction memory's rd/wn/address/write_data/read_data port.
- Arbitrates per cycle with a bounded-burst ownership FSM, so neither side is starved.
- Returns registered read data to fetch and rejects out-of-range addresses.

---
 rtl/imem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter between fetch (read) and loader (write), using bounded-burst ownership.
// Define IMEM_ARB_PERF_EN to add the grant and stall performance counters.
module imem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2048,
  parameter int MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [DATA_W-1:0] f_rdata_o,
  output logic              f_err_o,
  input  logic              l_req_i,
  input  logic [ADDR_W-1:0] l_addr_i,
  input  logic [DATA_W-1:0] l_wdata_i,
  output logic              l_gnt_o,
  output logic              l_err_o,
  output logic              mem_rd_o,
  output logic              mem_wn_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  input  logic [DATA_W-1:0] mem_read_data_i
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]       f_cnt_o,
  output logic [31:0]       l_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int                CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_BURST);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH_OWN, LOAD_OWN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   burst_q, burst_d;
  logic               f_rvalid_q, f_err_q, l_err_q;
  logic [DATA_W-1:0]  f_rdata_q, f_rdata_d;
  logic               f_gnt, l_gnt;
  logic               f_in_range, l_in_range;
  logic [CNT_W-1:0]   burst_inc;

  assign f_in_range = {1'b0, f_addr_i} < DEPTH_EXT;
  assign l_in_range = {1'b0, l_addr_i} < DEPTH_EXT;
  assign burst_inc  = (burst_q == MAX_CNT) ? MAX_CNT : burst_q + 1'b1;

  // NOTE: every signal gets a default at the top of the block, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    state_d = IDLE;
    burst_d = '0;
    unique case (state_q)
      IDLE: begin
        if (l_req_i)      l_gnt = 1'b1;
        else if (f_req_i) f_gnt = 1'b1;
      end
      FETCH_OWN: begin
        if (f_req_i && (burst_q < MAX_CNT || !l_req_i)) f_gnt = 1'b1;
        else if (l_req_i)                               l_gnt = 1'b1;
      end
      LOAD_OWN: begin
        if (l_req_i && (burst_q < MAX_CNT || !f_req_i)) l_gnt = 1'b1;
        else if (f_req_i)                               f_gnt = 1'b1;
      end
      default: ;
    endcase
    // Reset wins over everything, so a burst cut by reset cannot write.
    if (rst_i) begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
    end
    if (f_gnt) begin
      state_d = FETCH_OWN;
      burst_d = (state_q == FETCH_OWN) ? burst_inc : CNT_W'(1);
    end else if (l_gnt) begin
      state_d = LOAD_OWN;
      burst_d = (state_q == LOAD_OWN) ? burst_inc : CNT_W'(1);
    end
    f_rdata_d = f_rdata_q;
    if (f_gnt) f_rdata_d = f_in_range ? mem_read_data_i : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      burst_q    <= '0;
      f_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      f_err_q    <= 1'b0;
      l_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      f_rvalid_q <= f_gnt;
      f_rdata_q  <= f_rdata_d;
      f_err_q    <= f_gnt & ~f_in_range;
      l_err_q    <= l_gnt & ~l_in_range;
    end
  end

  assign f_gnt_o          = f_gnt;
  assign l_gnt_o          = l_gnt;
  assign f_rvalid_o       = f_rvalid_q;
  assign f_rdata_o        = f_rdata_q;
  assign f_err_o          = f_err_q;
  assign l_err_o          = l_err_q;
  assign mem_rd_o         = ~l_gnt;
  assign mem_wn_o         = l_gnt & l_in_range;
  assign mem_address_o    = f_gnt ? f_addr_i : (l_gnt ? l_addr_i : '0);
  assign mem_write_data_o = l_gnt ? l_wdata_i : '0;

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] f_cnt_q, l_cnt_q, stall_cnt_q;
  logic        stall;

  // A cycle stalls when either side is pending and not granted.
  assign stall = (f_req_i & ~f_gnt) | (l_req_i & ~l_gnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f_cnt_q     <= '0;
      l_cnt_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      f_cnt_q     <= f_cnt_q + {31'd0, f_gnt};
      l_cnt_q     <= l_cnt_q + {31'd0, l_gnt};
      stall_cnt_q <= stall_cnt_q + {31'd0, stall};
    end
  end

  assign f_cnt_o     = f_cnt_q;
  assign l_cnt_o     = l_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
